// File: rtl/bus_pkg.sv
// ============================================================================
// Module      : bus_pkg
// Description : Shared types and constants for the two-master bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic M_CPU           = 1'b0;
   localparam logic M_DMA           = 1'b1;
   localparam int   TIMEOUT_DEFAULT = 15;
   localparam logic ERR_RDATA_BIT   = 1'b0;

endpackage

`default_nettype wire

// File: rtl/bus_rr_pick.sv
// ============================================================================
// Module      : bus_rr_pick
// Description : Combinational two-way round-robin selector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_rr_pick
   import bus_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic       winner,
   output logic       any_req
);

   always_comb begin
      any_req = |req;
      winner  = M_CPU;
      // On a tie the master that did not win last time takes the bus
      if (req == 2'b11) begin
         winner = ~last_gnt;
      end else if (req[1]) begin
         winner = M_DMA;
      end
   end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module      : bus_arbiter
// Description : Two-master round-robin arbiter and access sequencer.
//               Optional access timeout enabled by BUS_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter
   import bus_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_req,
   input  logic          m1_req,
   input  logic [AW-1:0] m0_addr,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic [DW-1:0] m1_wdata,
   input  logic          m0_rw,
   input  logic          m1_rw,
   output logic          m0_gnt,
   output logic          m1_gnt,
   output logic          m0_ack,
   output logic          m1_ack,
   output logic [DW-1:0] m0_rdata,
   output logic [DW-1:0] m1_rdata,
   output logic [AW-1:0] bc_addr,
   output logic [DW-1:0] bc_wdata,
   output logic          bc_rw,
   output logic          bc_valid,
   input  logic [DW-1:0] bc_rdata,
   input  logic          bc_ready,
   output logic          err
);

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_winner;
   logic          r_last_gnt;
   logic [AW-1:0] r_bc_addr;
   logic [DW-1:0] r_bc_wdata;
   logic          r_bc_rw;
   logic [DW-1:0] r_m0_rdata;
   logic [DW-1:0] r_m1_rdata;
   logic          w_pick;
   logic          w_any;
   logic          w_timeout;

   if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_timeout_range
      $error("bus_arbiter: TIMEOUT must fit the 4-bit wait counter (1..15)");
   end

   bus_rr_pick u_pick (
      .req      ({m1_req, m0_req}),
      .last_gnt (r_last_gnt),
      .winner   (w_pick),
      .any_req  (w_any)
   );

`ifdef BUS_ARB_TIMEOUT_EN
   logic [3:0] r_tcnt;
   logic       r_err;

   // Fires on the ACCESS cycle that would make the counter reach TIMEOUT
   assign w_timeout = (r_state == ST_ACCESS) && !bc_ready &&
                      (r_tcnt == 4'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tcnt <= 4'd0;
         r_err  <= 1'b0;
      end else begin
         if (r_state == ST_ACCESS) begin
            r_err <= w_timeout;
            if (!bc_ready) begin
               r_tcnt <= r_tcnt + 4'd1;
            end
         end else if (r_state == ST_IDLE) begin
            r_tcnt <= 4'd0;
            r_err  <= 1'b0;
         end
      end
   end

   assign err = r_err && (r_state == ST_RESP);
`else
   assign w_timeout = 1'b0;
   assign err       = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_any) w_state_nxt = ST_ACCESS;
         ST_ACCESS: if (bc_ready || w_timeout) w_state_nxt = ST_RESP;
         ST_RESP:   w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_winner   <= M_CPU;
         r_last_gnt <= M_DMA;
         r_bc_addr  <= '0;
         r_bc_wdata <= '0;
         r_bc_rw    <= 1'b0;
         r_m0_rdata <= '0;
         r_m1_rdata <= '0;
      end else begin
         if (r_state == ST_IDLE && w_any) begin
            r_winner   <= w_pick;
            r_last_gnt <= w_pick;
            r_bc_addr  <= (w_pick == M_DMA) ? m1_addr  : m0_addr;
            r_bc_wdata <= (w_pick == M_DMA) ? m1_wdata : m0_wdata;
            r_bc_rw    <= (w_pick == M_DMA) ? m1_rw    : m0_rw;
         end
         if (r_state == ST_ACCESS) begin
            // Ready takes priority over a simultaneous timeout
            if (bc_ready) begin
               if (!r_bc_rw) begin
                  if (r_winner == M_DMA) r_m1_rdata <= bc_rdata;
                  else                   r_m0_rdata <= bc_rdata;
               end
            end else if (w_timeout) begin
               if (r_winner == M_DMA) r_m1_rdata <= {DW{ERR_RDATA_BIT}};
               else                   r_m0_rdata <= {DW{ERR_RDATA_BIT}};
            end
         end
      end
   end

   assign m0_gnt   = (r_state != ST_IDLE) && (r_winner == M_CPU);
   assign m1_gnt   = (r_state != ST_IDLE) && (r_winner == M_DMA);
   assign m0_ack   = (r_state == ST_RESP) && (r_winner == M_CPU);
   assign m1_ack   = (r_state == ST_RESP) && (r_winner == M_DMA);
   assign m0_rdata = r_m0_rdata;
   assign m1_rdata = r_m1_rdata;
   assign bc_addr  = r_bc_addr;
   assign bc_wdata = r_bc_wdata;
   assign bc_rw    = r_bc_rw;
   assign bc_valid = (r_state == ST_ACCESS);

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Self-checking bench for bus_arbiter with a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          m0_req = 1'b0, m1_req = 1'b0;
   logic [AW-1:0] m0_addr = '0, m1_addr = '0;
   logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
   logic          m0_rw = 1'b0, m1_rw = 1'b0;
   logic          m0_gnt, m1_gnt, m0_ack, m1_ack;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic [AW-1:0] bc_addr;
   logic [DW-1:0] bc_wdata;
   logic          bc_rw, bc_valid, err;
   logic [DW-1:0] bc_rdata = '0;
   logic          bc_ready = 1'b0;

   int            checks = 0;
   int            failures = 0;
   int            last_id;
   logic [DW-1:0] exp_rd [2];

   bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m1_req(m1_req),
      .m0_addr(m0_addr), .m1_addr(m1_addr),
      .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
      .m0_rw(m0_rw), .m1_rw(m1_rw),
      .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
      .m0_ack(m0_ack), .m1_ack(m1_ack),
      .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
      .bc_addr(bc_addr), .bc_wdata(bc_wdata), .bc_rw(bc_rw),
      .bc_valid(bc_valid), .bc_rdata(bc_rdata), .bc_ready(bc_ready),
      .err(err)
   );

   always #5 clk = ~clk;

   // Round-robin rule: lone requester wins, on a tie the one not served last
   function automatic int pick(input logic r0, input logic r1, input int last);
      if (r0 && r1) return (last == 0) ? 1 : 0;
      if (r1) return 1;
      return 0;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic scramble_masters;
      m0_addr  = $urandom; m1_addr  = $urandom;
      m0_wdata = $urandom; m1_wdata = $urandom;
      m0_rw    = 1'($urandom_range(0, 1));
      m1_rw    = 1'($urandom_range(0, 1));
   endtask

   task automatic do_reset;
      rst_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0; bc_ready = 1'b0;
      repeat (2) tick;
      rst_n = 1'b1;
      tick;
      last_id = 1; exp_rd[0] = '0; exp_rd[1] = '0;
   endtask

   task automatic test_reset;
      logic [DW-1:0] rd;
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         m0_req = 1'($urandom_range(0, 1)); m1_req = 1'($urandom_range(0, 1));
         scramble_masters;
         bc_ready = 1'($urandom_range(0, 1)); bc_rdata = $urandom;
         tick;
         checks++;
         if ({m0_gnt, m1_gnt, m0_ack, m1_ack, bc_valid, bc_rw, err} !== 7'd0 ||
             m0_rdata !== '0 || m1_rdata !== '0 || bc_addr !== '0 || bc_wdata !== '0) begin
            failures++;
            $display("FAIL reset_outputs: gnt=%b%b ack=%b%b valid=%b rw=%b err=%b addr=%h wdata=%h rd0=%h rd1=%h required all zero",
                     m1_gnt, m0_gnt, m1_ack, m0_ack, bc_valid, bc_rw, err, bc_addr, bc_wdata, m0_rdata, m1_rdata);
         end
      end
      m0_req = 1'b0; m1_req = 1'b0; bc_ready = 1'b0;
      rst_n = 1'b1;
      last_id = 1; exp_rd[0] = '0; exp_rd[1] = '0;
      tick;
      m0_addr = 32'hA0; m1_addr = 32'hB0; m0_rw = 1'b0; m1_rw = 1'b0;
      m0_req = 1'b1; m1_req = 1'b1;
      tick;
      checks++;
      if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || bc_addr !== 32'hA0) begin
         failures++;
         $display("FAIL first_tie: gnt=%b%b addr=%h required gnt=01 addr=000000a0", m1_gnt, m0_gnt, bc_addr);
      end
      m0_req = 1'b0; m1_req = 1'b0;
      rd = $urandom; bc_rdata = rd; bc_ready = 1'b1;
      tick;
      bc_ready = 1'b0;
      last_id = 0; exp_rd[0] = rd;
      checks++;
      if (m0_ack !== 1'b1 || m0_rdata !== rd) begin
         failures++;
         $display("FAIL first_tie_ack: ack=%b rdata=%h required ack=1 rdata=%h", m0_ack, m0_rdata, rd);
      end
      tick;
   endtask

   task automatic test_single_read;
      m0_addr = 32'h000F_FF00; m0_rw = 1'b0; m0_req = 1'b1;
      tick;
      checks++;
      if (bc_valid !== 1'b1 || bc_addr !== 32'h000F_FF00 || bc_rw !== 1'b0 || m0_gnt !== 1'b1) begin
         failures++;
         $display("FAIL read_cycle1: valid=%b addr=%h rw=%b gnt=%b required 1 000fff00 0 1", bc_valid, bc_addr, bc_rw, m0_gnt);
      end
      m0_req = 1'b0; bc_ready = 1'b1; bc_rdata = 32'h1234_5678;
      tick;
      bc_ready = 1'b0; bc_rdata = 32'hDEAD_BEEF;
      checks++;
      if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || bc_valid !== 1'b0 || m0_rdata !== 32'h1234_5678) begin
         failures++;
         $display("FAIL read_cycle2: ack=%b%b valid=%b rdata=%h required ack=01 valid=0 rdata=12345678",
                  m1_ack, m0_ack, bc_valid, m0_rdata);
      end
      tick;
      checks++;
      if (m0_ack !== 1'b0 || bc_valid !== 1'b0 || m0_gnt !== 1'b0 || m0_rdata !== 32'h1234_5678) begin
         failures++;
         $display("FAIL read_cycle3: ack=%b valid=%b gnt=%b rdata=%h required 0 0 0 12345678", m0_ack, bc_valid, m0_gnt, m0_rdata);
      end
      last_id = 0; exp_rd[0] = 32'h1234_5678;
   endtask

   task automatic test_round_robin;
      int win;
      logic [AW-1:0] exp_addr;
      do_reset;
      m0_addr = 32'h100; m1_addr = 32'h200; m0_rw = 1'b0; m1_rw = 1'b0;
      bc_rdata = 32'h5555_AAAA; bc_ready = 1'b1;
      m0_req = 1'b1; m1_req = 1'b1;
      for (int t = 0; t < 4; t++) begin
         win = pick(1'b1, 1'b1, last_id);
         exp_addr = (t % 2 == 0) ? 32'h100 : 32'h200;
         tick;
         checks++;
         if (bc_addr !== exp_addr || bc_valid !== 1'b1 || (m0_gnt && m1_gnt) ||
             {m1_gnt, m0_gnt} !== ((win == 1) ? 2'b10 : 2'b01) ||
             bc_addr !== ((win == 1) ? m1_addr : m0_addr)) begin
            failures++;
            $display("FAIL rr_access[%0d]: addr=%h gnt=%b%b valid=%b required addr=%h winner=m%0d",
                     t, bc_addr, m1_gnt, m0_gnt, bc_valid, exp_addr, win);
         end
         last_id = win;
         exp_rd[win] = bc_rdata;
         tick;
         checks++;
         if ({m1_ack, m0_ack} !== ((win == 1) ? 2'b10 : 2'b01) || (m0_gnt && m1_gnt)) begin
            failures++;
            $display("FAIL rr_ack[%0d]: ack=%b%b gnt=%b%b required winner=m%0d", t, m1_ack, m0_ack, m1_gnt, m0_gnt, win);
         end
         tick;
         if (t == 3) begin
            m0_req = 1'b0; m1_req = 1'b0; bc_ready = 1'b0;
         end
         checks++;
         if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || bc_valid !== 1'b0) begin
            failures++;
            $display("FAIL rr_idle[%0d]: gnt=%b%b valid=%b required 00 0", t, m1_gnt, m0_gnt, bc_valid);
         end
      end
      tick;
   endtask

   task automatic test_write_wait;
      m0_req = 1'b0;
      m1_addr = 32'h0000_0040; m1_wdata = 32'hCAFE_F00D; m1_rw = 1'b1; m1_req = 1'b1;
      tick;
      m1_req = 1'b0;
      scramble_masters;
      for (int c = 1; c <= 4; c++) begin
         checks++;
         if (bc_valid !== 1'b1 || bc_addr !== 32'h40 || bc_wdata !== 32'hCAFE_F00D ||
             bc_rw !== 1'b1 || m1_gnt !== 1'b1 || m1_ack !== 1'b0) begin
            failures++;
            $display("FAIL write_wait[%0d]: valid=%b addr=%h wdata=%h rw=%b gnt=%b ack=%b required 1 00000040 cafef00d 1 1 0",
                     c, bc_valid, bc_addr, bc_wdata, bc_rw, m1_gnt, m1_ack);
         end
         bc_ready = (c == 4); bc_rdata = $urandom;
         tick;
      end
      bc_ready = 1'b0;
      last_id = 1;
      checks++;
      if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || bc_valid !== 1'b0 || m1_rdata !== exp_rd[1]) begin
         failures++;
         $display("FAIL write_ack: ack=%b%b valid=%b rdata=%h required ack=10 valid=0 rdata=%h",
                  m1_ack, m0_ack, bc_valid, m1_rdata, exp_rd[1]);
      end
      tick;
      checks++;
      if (bc_valid !== 1'b0 || bc_addr !== 32'h40 || m1_gnt !== 1'b0 || m1_ack !== 1'b0) begin
         failures++;
         $display("FAIL write_hold: valid=%b addr=%h gnt=%b ack=%b required 0 00000040 0 0", bc_valid, bc_addr, m1_gnt, m1_ack);
      end
   endtask

   task automatic test_random;
      logic          r0, r1, e_rw;
      int            win, waits;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata, rd;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            m0_req = 1'b0; m1_req = 1'b0;
            tick;
            checks++;
            if (bc_valid !== 1'b0 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
               failures++;
               $display("FAIL rnd_noreq[%0d]: valid=%b gnt=%b%b required 0 00", i, bc_valid, m1_gnt, m0_gnt);
            end
         end
         r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1));
         if (!r0 && !r1) r0 = 1'b1;
         scramble_masters;
         m0_req = r0; m1_req = r1;
         win     = pick(r0, r1, last_id);
         e_addr  = (win == 1) ? m1_addr  : m0_addr;
         e_wdata = (win == 1) ? m1_wdata : m0_wdata;
         e_rw    = (win == 1) ? m1_rw    : m0_rw;
         waits   = $urandom_range(0, 3);
         tick;
         last_id = win;
         m0_req = 1'b0; m1_req = 1'b0;
         scramble_masters;
         for (int w = 0; w <= waits; w++) begin
            checks++;
            if (bc_valid !== 1'b1 || bc_addr !== e_addr || bc_wdata !== e_wdata || bc_rw !== e_rw ||
                {m1_gnt, m0_gnt} !== ((win == 1) ? 2'b10 : 2'b01) || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
               failures++;
               $display("FAIL rnd_access[%0d.%0d]: valid=%b addr=%h wdata=%h rw=%b gnt=%b%b required addr=%h wdata=%h rw=%b winner=m%0d",
                        i, w, bc_valid, bc_addr, bc_wdata, bc_rw, m1_gnt, m0_gnt, e_addr, e_wdata, e_rw, win);
            end
            rd = $urandom; bc_rdata = rd;
            bc_ready = (w == waits);
            tick;
         end
         bc_ready = 1'b0;
         if (!e_rw) exp_rd[win] = rd;
         checks++;
         if ({m1_ack, m0_ack} !== ((win == 1) ? 2'b10 : 2'b01) || bc_valid !== 1'b0 || err !== 1'b0 ||
             m0_rdata !== exp_rd[0] || m1_rdata !== exp_rd[1]) begin
            failures++;
            $display("FAIL rnd_resp[%0d]: ack=%b%b valid=%b err=%b rd0=%h rd1=%h required winner=m%0d rd0=%h rd1=%h",
                     i, m1_ack, m0_ack, bc_valid, err, m0_rdata, m1_rdata, win, exp_rd[0], exp_rd[1]);
         end
         tick;
         checks++;
         if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0 ||
             m0_rdata !== exp_rd[0] || m1_rdata !== exp_rd[1]) begin
            failures++;
            $display("FAIL rnd_idle[%0d]: gnt=%b%b ack=%b%b rd0=%h rd1=%h required 00 00 %h %h",
                     i, m1_gnt, m0_gnt, m1_ack, m0_ack, m0_rdata, m1_rdata, exp_rd[0], exp_rd[1]);
         end
      end
   endtask

   task automatic test_timeout;
      m0_addr = 32'h0000_0800; m0_rw = 1'b0; m0_req = 1'b1; m1_req = 1'b0; bc_ready = 1'b0;
      tick;
      m0_req = 1'b0;
      last_id = 0;
`ifdef BUS_ARB_TIMEOUT_EN
      for (int k = 1; k <= 15; k++) begin
         checks++;
         if (bc_valid !== 1'b1 || m0_ack !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_wait[%0d]: valid=%b ack=%b err=%b required 1 0 0", k, bc_valid, m0_ack, err);
         end
         tick;
      end
      exp_rd[0] = '0;
      checks++;
      if (m0_ack !== 1'b1 || err !== 1'b1 || m0_rdata !== '0 || bc_valid !== 1'b0) begin
         failures++;
         $display("FAIL timeout_resp: ack=%b err=%b rdata=%h valid=%b required 1 1 00000000 0", m0_ack, err, m0_rdata, bc_valid);
      end
      tick;
      checks++;
      if (err !== 1'b0 || m0_ack !== 1'b0) begin
         failures++;
         $display("FAIL timeout_after: err=%b ack=%b required 0 0", err, m0_ack);
      end
`else
      repeat (99) tick;
      checks++;
      if (bc_valid !== 1'b1 || err !== 1'b0 || m0_ack !== 1'b0 || m0_gnt !== 1'b1) begin
         failures++;
         $display("FAIL no_timeout: valid=%b err=%b ack=%b gnt=%b required 1 0 0 1", bc_valid, err, m0_ack, m0_gnt);
      end
      bc_rdata = 32'h0BAD_F00D; bc_ready = 1'b1;
      tick;
      bc_ready = 1'b0;
      exp_rd[0] = 32'h0BAD_F00D;
      checks++;
      if (m0_ack !== 1'b1 || err !== 1'b0 || m0_rdata !== 32'h0BAD_F00D) begin
         failures++;
         $display("FAIL no_timeout_ack: ack=%b err=%b rdata=%h required 1 0 0badf00d", m0_ack, err, m0_rdata);
      end
      tick;
`endif
   endtask

   task automatic test_reset_mid;
      do_reset;
      m0_addr = 32'h300; m1_addr = 32'h400; m0_rw = 1'b0; m1_rw = 1'b0;
      m0_req = 1'b1; m1_req = 1'b1;
      tick;
      m0_req = 1'b0; m1_req = 1'b0;
      tick;
      checks++;
      if (bc_valid !== 1'b1 || m0_gnt !== 1'b1) begin
         failures++;
         $display("FAIL mid_pre: valid=%b gnt0=%b required 1 1", bc_valid, m0_gnt);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bc_valid !== 1'b0 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || m0_ack !== 1'b0 || err !== 1'b0) begin
         failures++;
         $display("FAIL mid_async: valid=%b gnt=%b%b ack=%b err=%b required 0 00 0 0", bc_valid, m1_gnt, m0_gnt, m0_ack, err);
      end
      bc_ready = 1'b1;
      tick;
      checks++;
      if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || err !== 1'b0 || bc_valid !== 1'b0) begin
         failures++;
         $display("FAIL mid_noack: ack=%b%b err=%b valid=%b required 00 0 0", m1_ack, m0_ack, err, bc_valid);
      end
      bc_ready = 1'b0;
      rst_n = 1'b1;
      last_id = 1; exp_rd[0] = '0; exp_rd[1] = '0;
      tick;
      m0_req = 1'b1; m1_req = 1'b1;
      tick;
      m0_req = 1'b0; m1_req = 1'b0;
      checks++;
      if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || bc_addr !== 32'h300) begin
         failures++;
         $display("FAIL mid_tie: gnt=%b%b addr=%h required 01 00000300", m1_gnt, m0_gnt, bc_addr);
      end
      bc_ready = 1'b1; bc_rdata = 32'h7777_0001;
      tick;
      bc_ready = 1'b0;
      tick;
      last_id = 0; exp_rd[0] = 32'h7777_0001;
   endtask

   initial begin
      last_id = 1; exp_rd[0] = '0; exp_rd[1] = '0;
      test_reset;
      test_single_read;
      test_round_robin;
      test_write_wait;
      test_random;
      test_timeout;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
